conv_result_drain: RTL and testbench
====================================

# conv_result_drain

Downstream stage of the 2x2 convolution kernel. After the convolution has finished writing its 7x7 result into the 8x8-addressed output buffer, this block reads the valid region back through the buffer's read port and streams it out as a valid/ready word stream in row-major order, tagging the final element. It absorbs the buffer's one-cycle read latency and output back-pressure with a small credit-controlled FIFO, so it sustains one word per cycle when the sink does not stall.

## Interface
Parameters:
- `DATA_W`, default 32: result word width.
- `ROW_W`, default 3: row field width of the buffer address.
- `COL_W`, default 3: column field width of the buffer address.
- `ROWS`, default 7: rows to drain (0..ROWS-1).
- `COLS`, default 7: columns to drain (0..COLS-1).
- `FIFO_DEPTH`, default 2: output buffer entries; must be ≥ 2.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `tstart`  in  1: one-cycle start pulse, issued by the controller after the convolution's final store.
- `busy`  out  1: high from the cycle after an accepted `tstart` until `done`.
- `done`  out  1: one-cycle completion pulse.
- `mem_addr`  out  ROW_W+COL_W: read address `{row, col}`.
- `mem_rd_en`  out  1: read strobe.
- `mem_rd_data`  in  DATA_W: read data, valid the cycle after `mem_rd_en`.
- `out_valid`  out  1: stream valid.
- `out_ready`  in  1: stream ready.
- `out_data`  out  DATA_W: result word.
- `out_last`  out  1: high with element (ROWS-1, COLS-1).

## Operation
- FSM states: IDLE, READ, DRAIN.
  - IDLE → READ when `tstart` is high. Row and column counters clear to 0.
  - READ issues reads. After the read of (ROWS-1, COLS-1) is issued, the FSM moves to DRAIN.
  - DRAIN → IDLE on the handshake of the element tagged `out_last`. `done` pulses in the following cycle.
- `tstart` is ignored outside IDLE.
- Read issue condition: state is READ and `occupancy + inflight − pop < FIFO_DEPTH`.
  - `inflight` is 1 if `mem_rd_en` was high in the previous cycle.
  - `pop` is `out_valid & out_ready`.
- On each issue, the column counter increments. At COLS-1 it wraps to 0 and the row counter increments.
- `mem_addr` is driven only when `mem_rd_en` is high. Its value is a don't-care otherwise.
- A last-tag bit travels with each read. It is registered alongside `mem_rd_en` and captured into the FIFO together with the data.
- FIFO: circular buffer with an occupancy counter.
  - Write and pop in the same cycle are legal: occupancy is unchanged.
  - The credit rule guarantees the FIFO never overflows. A bench assertion checks this.
- Arithmetic: counters are ROW_W/COL_W bits wide, and the occupancy counter is clog2(FIFO_DEPTH+1) bits. No data arithmetic.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_rd_en`=0, `out_valid`=0, `out_last`=0, `out_data`=0. FSM goes to IDLE, FIFO is emptied, counters clear.
- Reset asserted mid-operation aborts the transfer immediately. No `done` pulse is produced, and the stale read return is discarded.
- `tstart` is seen in cycle 0:
  - `busy` and the first `mem_rd_en` (address 0) occur in cycle 1.
  - Data is captured at the end of cycle 2.
  - `out_valid` is high in cycle 3.
- With `out_ready` held high, one word per cycle. The last handshake is in cycle 3+ROWS·COLS−1 = 51, and `done` is in cycle 52 for default parameters.
- `out_valid`/`out_data`/`out_last` hold stable while `out_valid & !out_ready`.
- `busy` deasserts in the same cycle `done` pulses.

## Structure
- Shared package `conv_pkg` holds:
  - the address typedef `{row, col}` with ROW_W=3 and COL_W=3;
  - DATA_W=32;
  - the FSM state enum.
- These are the same constants the convolution kernel uses for its output buffer.
- One natural sub-module: `conv_drain_fifo`, a parameterised synchronous FIFO with async active-low reset, exposing occupancy for the credit check.

## Test plan
- Buffer preloaded with word = 8·row+col, `out_ready`=1, `tstart` pulse → 49 words 0,1,…,6,8,…,54 (the col-7 words 7,15,… never appear), `out_last` only on 54, `done` in cycle 52.
- Same preload, `out_ready` toggling 1,0,1,0 → identical sequence, no drops or duplicates, `mem_rd_en` never issued when FIFO plus in-flight reaches 2, data held stable while stalled.
- `out_ready`=0 for 20 cycles after start → exactly 2 reads issued (addresses 0 and 1), `out_valid` stays high with data 0; after release the full sequence completes.
- Second `tstart` pulse in cycle 10 while busy → ignored; exactly 49 words and one `done`.
- `rst_n` low in cycle 20, then a new `tstart` → all outputs at reset values, no `done` for the aborted run, the new run restarts at address 0.
- Back-to-back runs (`tstart` the cycle after `done`) → two complete 49-word streams with a one-cycle gap minimum.

Source files
------------

// File: rtl/conv_pkg.sv
// Constants and types shared by the 2x2 convolution kernel and its result drain.
// The address layout matches the kernel's 8x8-addressed output buffer.
package conv_pkg;

  localparam int CONV_DATA_W = 32;
  localparam int CONV_ROW_W  = 3;
  localparam int CONV_COL_W  = 3;

  typedef struct packed {
    logic [CONV_ROW_W-1:0] row;
    logic [CONV_COL_W-1:0] col;
  } conv_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } drain_state_e;

endpackage

// File: rtl/conv_drain_fifo.sv
// Small circular-buffer FIFO with an occupancy counter, used to absorb the
// buffer read latency and output back-pressure in the result drain.
module conv_drain_fifo #(
  parameter int W = 33,
  parameter int DEPTH = 2,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic [OCC_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] count_r;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  // Storage, pointer and occupancy update; simultaneous write and read keep the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= W'(0);
      end
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= OCC_W'(0);
    end else begin
      if (wr_en) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (rd_en) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({wr_en, rd_en})
        2'b10:   count_r <= count_r + OCC_W'(1);
        2'b01:   count_r <= count_r - OCC_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;

endmodule

// File: rtl/conv_result_drain.sv
// Reads the convolution result region back from the output buffer and streams
// it out row-major as a valid/ready word stream, tagging the final element.
module conv_result_drain
  import conv_pkg::*;
#(
  parameter int DATA_W     = CONV_DATA_W,
  parameter int ROW_W      = CONV_ROW_W,
  parameter int COL_W      = CONV_COL_W,
  parameter int ROWS       = 7,
  parameter int COLS       = 7,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tstart,
  output logic                   busy,
  output logic                   done,
  output logic [ROW_W+COL_W-1:0] mem_addr,
  output logic                   mem_rd_en,
  input  logic [DATA_W-1:0]      mem_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = OCC_W + 1;

  drain_state_e     state_r;
  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] col_r;
  logic             busy_r;
  logic             done_r;
  logic             inflight_r;
  logic             inflight_last_r;

  logic [OCC_W-1:0] fifo_count_s;
  logic [DATA_W:0]  fifo_rd_data_s;
  logic             pop_s;
  logic [SUM_W-1:0] credit_sum_s;
  logic             issue_s;
  logic             at_last_col_s;
  logic             issue_last_s;

  // Credit check: FIFO entries plus the returning read, less this cycle's pop, must leave room
  always_comb begin
    pop_s         = out_valid & out_ready;
    credit_sum_s  = {1'b0, fifo_count_s} + SUM_W'(inflight_r) - SUM_W'(pop_s);
    issue_s       = (state_r == ST_READ) && (credit_sum_s < SUM_W'(FIFO_DEPTH));
    at_last_col_s = (col_r == COL_W'(COLS - 1));
    issue_last_s  = issue_s && at_last_col_s && (row_r == ROW_W'(ROWS - 1));
  end

  // Control FSM, address counters and the read-return pipeline stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      row_r           <= ROW_W'(0);
      col_r           <= COL_W'(0);
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      done_r          <= 1'b0;
      inflight_r      <= issue_s;
      inflight_last_r <= issue_last_s;
      case (state_r)
        ST_IDLE: begin
          if (tstart) begin
            state_r <= ST_READ;
            row_r   <= ROW_W'(0);
            col_r   <= COL_W'(0);
            busy_r  <= 1'b1;
          end
        end
        ST_READ: begin
          if (issue_s) begin
            if (at_last_col_s) begin
              col_r <= COL_W'(0);
              row_r <= row_r + ROW_W'(1);
            end else begin
              col_r <= col_r + COL_W'(1);
            end
            if (issue_last_s) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop_s && out_last) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  conv_drain_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (inflight_r),
    .wr_data ({inflight_last_r, mem_rd_data}),
    .rd_en   (pop_s),
    .rd_data (fifo_rd_data_s),
    .count   (fifo_count_s)
  );

  assign busy      = busy_r;
  assign done      = done_r;
  assign mem_rd_en = issue_s;
  assign mem_addr  = {row_r, col_r};
  assign out_valid = (fifo_count_s != OCC_W'(0));
  assign out_data  = fifo_rd_data_s[DATA_W-1:0];
  assign out_last  = fifo_rd_data_s[DATA_W];

endmodule

// File: tb/tb_conv_result_drain.sv
// Directed bench for conv_result_drain: buffer model preloaded with 8*row+col,
// stream scoreboard, credit and hold checks, and cycle-accurate timing checks.
module tb_conv_result_drain;
  import conv_pkg::*;

  localparam int N = 49;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tstart;
  logic        busy;
  logic        done;
  logic [5:0]  mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  logic [31:0] mem_model [64];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int pop_cnt, rd_cnt, done_cnt, start_cyc;
  int first_rd_rel, first_valid_rel, last_hs_rel, done_rel, rel;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;

  conv_result_drain #(
    .DATA_W(32), .ROW_W(3), .COL_W(3), .ROWS(7), .COLS(7), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tstart(tstart), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output buffer read port: one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem_model[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k);
    int j;
    j = k % N;
    return 32'(8 * (j / 7) + (j % 7));
  endfunction

  function automatic logic [5:0] exp_addr(input int k);
    conv_addr_t a;
    int j;
    j = k % N;
    a.row = 3'(j / 7);
    a.col = 3'(j % 7);
    return a;
  endfunction

  task automatic sb_clear();
    pop_cnt = 0; rd_cnt = 0; done_cnt = 0; start_cyc = cyc;
    first_rd_rel = -1; first_valid_rel = -1; last_hs_rel = -1; done_rel = -1;
    prev_stall = 1'b0;
  endtask

  // Stream monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      rel = cyc - start_cyc;
      if (mem_rd_en) begin
        check_eq("credit", ((rd_cnt - pop_cnt - ((out_valid && out_ready) ? 1 : 0)) < 2), 1);
        check_eq("rd_addr", mem_addr, exp_addr(rd_cnt));
        if (rd_cnt == 0) first_rd_rel = rel;
        rd_cnt++;
      end
      if (prev_stall) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, prev_data);
        check_eq("hold_last", out_last, prev_last);
      end
      if (out_valid && first_valid_rel < 0) first_valid_rel = rel;
      if (out_valid && out_ready) begin
        check_eq("data", out_data, exp_word(pop_cnt));
        check_eq("last", out_last, ((pop_cnt % N) == N - 1));
        if ((pop_cnt % N) == N - 1) last_hs_rel = rel;
        pop_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
        check_eq("busy_at_done", busy, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_for(input int mode, input int n);
    case (mode)
      1:       return (n % 2) == 0;
      2:       return n >= 20;
      default: return 1'b1;
    endcase
  endfunction

  // mode 0: ready high, 1: toggling, 2: stalled 20 cycles, 3: extra tstart in cycle 10
  task automatic run(input int mode);
    int n;
    sb_clear();
    tstart = 1'b1;
    out_ready = ready_for(mode, 0);
    tick();
    check_eq("busy_cycle1", busy, 1);
    n = 1;
    while (done_cnt == 0 && n < 300) begin
      tstart = (mode == 3 && n == 10);
      out_ready = ready_for(mode, n);
      if (mode == 2 && n == 20) begin
        check_eq("stall_reads", rd_cnt, 2);
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_data", out_data, 0);
      end
      tick();
      n++;
    end
    tstart = 1'b0;
    check_eq("done_in_budget", (done_cnt > 0), 1);
    check_eq("word_count", pop_cnt, N);
    check_eq("read_count", rd_cnt, N);
    check_eq("done_count", done_cnt, 1);
    check_eq("busy_after", busy, 0);
    if (mode == 0) begin
      check_eq("first_rd_cycle", first_rd_rel, 1);
      check_eq("first_valid_cycle", first_valid_rel, 3);
      check_eq("last_hs_cycle", last_hs_rel, 51);
      check_eq("done_cycle", done_rel, 52);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 64; a++) mem_model[a] = 32'(a);
    mem_rd_data = 32'd0;
    rst_n = 1'b0; tstart = 1'b0; out_ready = 1'b0;
    sb_clear();
    tick(); tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rd_en", mem_rd_en, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_last", out_last, 0);
    check_eq("rst_data", out_data, 0);
    rst_n = 1'b1;
    tick();

    run(0);
    run(1);
    run(2);
    run(3);

    // Abort mid-run with reset, then restart
    sb_clear();
    tstart = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      tstart = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_rd_en", mem_rd_en, 0);
    check_eq("abort_valid", out_valid, 0);
    check_eq("abort_last", out_last, 0);
    check_eq("abort_data", out_data, 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    check_eq("abort_no_done", done_cnt, 0);
    check_eq("abort_idle_valid", out_valid, 0);
    run(0);

    // Back-to-back: second start in the cycle after done
    run(0);
    run(0);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
